// File: rtl/instr_fetch_decode_pkg.sv
// Shared definitions for the instruction fetch/decode block.
//   - state_t      : fetch FSM states (IDLE, REQ, WAIT, HOLD)
//   - SE_*         : SignOp codes understood by the downstream sign extender
//   - OP_*         : opcode match constants, left-aligned on instr[31:...]
//   - mov_signop() : builds the MOVZ SignOp code from the hw shift field
package instr_fetch_decode_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [2:0] SE_I     = 3'b000;
    localparam logic [2:0] SE_D     = 3'b001;
    localparam logic [2:0] SE_B     = 3'b010;
    localparam logic [2:0] SE_CB    = 3'b011;
    localparam logic [2:0] SE_MOV0  = 3'b100;
    localparam logic [2:0] SE_MOV16 = 3'b101;
    localparam logic [2:0] SE_MOV32 = 3'b110;
    localparam logic [2:0] SE_MOV48 = 3'b111;

    // 12-bit immediate ALU forms, instr[31:22]
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [9:0]  OP_ANDI = 10'b1001001000;
    localparam logic [9:0]  OP_ORRI = 10'b1011001000;
    // loads/stores, instr[31:21]
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    // unconditional branches, instr[31:26]
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [5:0]  OP_BL   = 6'b100101;
    // compare-and-branch, instr[31:24]
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    // move wide, instr[31:23]
    localparam logic [8:0]  OP_MOVZ = 9'b110100101;

    // MOVZ codes are SE_MOV0 + hw, i.e. {1, hw}
    function automatic logic [2:0] mov_signop(input logic [1:0] hw);
        return {1'b1, hw};
    endfunction

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Instruction memory request/response bus.
//   imem_req   : one-cycle fetch request strobe (master -> slave)
//   imem_addr  : fetch address, valid while imem_req=1 (master -> slave)
//   imem_ack   : response strobe (slave -> master)
//   imem_rdata : instruction word, valid with imem_ack (slave -> master)
interface instr_fetch_decode_if #(
    parameter int ADDR_W = 64
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_decode_signop_decode.sv
// signop_decode: maps the top opcode bits of an instruction to the sign
// extender control code.
//   op      : instr[31:21]
//   sign_op : SignOp code (SE_* from the package); unknown opcodes give SE_I
module signop_decode
    import instr_fetch_decode_pkg::*;
(
    input  logic [10:0] op,
    output logic [2:0]  sign_op
);

    // op[10] is instr[31], so shorter opcodes compare against the upper slice
    always_comb begin
        sign_op = SE_I;
        if (op[10:2] == OP_MOVZ) begin
            sign_op = mov_signop(op[1:0]);
        end else if (op[10:3] == OP_CBZ || op[10:3] == OP_CBNZ) begin
            sign_op = SE_CB;
        end else if (op[10:5] == OP_B || op[10:5] == OP_BL) begin
            sign_op = SE_B;
        end else if (op == OP_LDUR || op == OP_STUR) begin
            sign_op = SE_D;
        end else if (op[10:1] == OP_ADDI || op[10:1] == OP_SUBI ||
                     op[10:1] == OP_ANDI || op[10:1] == OP_ORRI) begin
            sign_op = SE_I;
        end
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: fetches one instruction at a time from instruction
// memory and presents it, with sign extender controls, to a valid/ready
// consumer. Taken branches (redirect) discard anything fetched on the old
// path.
//   CLK, resetl      : clock, asynchronous active-low reset
//   imem             : instruction memory bus (master side)
//   redirect, redirect_pc : branch/jump target override
//   out_valid/out_ready   : output handshake
//   out_pc, out_instr     : presented instruction and its PC
//   Imm, SignOp           : out_instr[25:0] and its extender control
// Build option: define IFD_SKID_BUF_EN to replace the single output register
// with a 2-entry FIFO so fetching continues while the consumer stalls.
module instr_fetch_decode
    import instr_fetch_decode_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 CLK,
    input  logic                 resetl,
    instr_fetch_decode_if.master imem,
    input  logic                 redirect,
    input  logic [ADDR_W-1:0]    redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_W-1:0]    out_pc,
    output logic [31:0]          out_instr,
    output logic [25:0]          Imm,
    output logic [2:0]           SignOp
);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] addr_q;
    logic              req_q;
    logic              drop;
    logic              hold_release;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;

`ifdef IFD_SKID_BUF_EN
    logic [ADDR_W-1:0] fifo_pc    [2];
    logic [31:0]       fifo_instr [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic              pop;

    assign pop          = (count != 2'd0) && out_ready;
    assign hold_release = pop;
    assign out_valid    = (count != 2'd0);
    assign out_pc       = fifo_pc[rd_ptr];
    assign out_instr    = fifo_instr[rd_ptr];
`else
    logic              valid_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       instr_q;

    assign hold_release = out_ready;
    assign out_valid    = valid_q;
    assign out_pc       = pc_q;
    assign out_instr    = instr_q;
`endif

    assign Imm = out_instr[25:0];

    signop_decode u_signop_decode (
        .op      (out_instr[31:21]),
        .sign_op (SignOp)
    );

    // Fetch FSM. imem_req is a registered one-cycle strobe raised on every
    // entry to REQ. The drop flag marks the single outstanding request as
    // belonging to a path abandoned by redirect, so its ack is swallowed.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            addr_q <= RESET_PC;
            req_q  <= 1'b0;
            drop   <= 1'b0;
`ifdef IFD_SKID_BUF_EN
            for (int i = 0; i < 2; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
`else
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
`endif
        end else begin
            req_q <= 1'b0;
`ifdef IFD_SKID_BUF_EN
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                count  <= count - 2'd1;
            end
`endif
            case (state)
                IDLE: begin
                    state <= REQ;
                    req_q <= 1'b1;
                    if (redirect) begin
                        pc     <= redirect_pc;
                        addr_q <= redirect_pc;
                    end else begin
                        addr_q <= pc;
                    end
                end
                REQ: begin
                    state <= WAIT;
                    if (redirect) begin
                        pc   <= redirect_pc;
                        drop <= 1'b1;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                        if (imem.imem_ack) begin
                            drop   <= 1'b0;
                            state  <= REQ;
                            req_q  <= 1'b1;
                            addr_q <= redirect_pc;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (imem.imem_ack) begin
                        if (drop) begin
                            drop   <= 1'b0;
                            state  <= REQ;
                            req_q  <= 1'b1;
                            addr_q <= pc;
                        end else begin
                            pc <= pc + ADDR_W'(4);
`ifdef IFD_SKID_BUF_EN
                            fifo_pc[wr_ptr]    <= pc;
                            fifo_instr[wr_ptr] <= imem.imem_rdata;
                            wr_ptr             <= ~wr_ptr;
                            count              <= pop ? count : count + 2'd1;
                            if (count == 2'd1 && !pop) begin
                                state <= HOLD;
                            end else begin
                                state  <= REQ;
                                req_q  <= 1'b1;
                                addr_q <= pc + ADDR_W'(4);
                            end
`else
                            valid_q <= 1'b1;
                            pc_q    <= pc;
                            instr_q <= imem.imem_rdata;
                            state   <= HOLD;
`endif
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc     <= redirect_pc;
                        state  <= REQ;
                        req_q  <= 1'b1;
                        addr_q <= redirect_pc;
`ifndef IFD_SKID_BUF_EN
                        valid_q <= 1'b0;
`endif
                    end else if (hold_release) begin
                        state  <= REQ;
                        req_q  <= 1'b1;
                        addr_q <= pc;
`ifndef IFD_SKID_BUF_EN
                        valid_q <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef IFD_SKID_BUF_EN
            // a taken branch invalidates everything buffered on the old path
            if (redirect) begin
                count  <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end
`endif
        end
    end

endmodule
